// File: rtl/dsp_sched_pkg.sv
// Shared types and helpers for the round-robin DSP scheduler.
package dsp_sched_pkg;

    localparam int ABD_WIDTH_DEF = 18;
    localparam int C_WIDTH_DEF   = 48;

    // The arbiter is written once for the largest supported requester count;
    // smaller instances zero-pad their valid vector up to MAX_N.
    localparam int MAX_N    = 8;
    localparam int ID_MAX_W = 3;

    typedef logic [ID_MAX_W-1:0] req_id_t;

    typedef struct packed {
        logic    found;
        req_id_t idx;
    } rr_pick_t;

    // Search for the first valid requester starting at ptr and wrapping.
    // Wrapping modulo MAX_N gives the same order as wrapping modulo N,
    // because the padded bits N..MAX_N-1 are always zero and get skipped.
    function automatic rr_pick_t rr_pick(input logic [MAX_N-1:0] valid, input req_id_t ptr);
        rr_pick_t r;
        req_id_t  idx;
        r = '0;
        for (int k = 0; k < MAX_N; k++) begin
            idx = ptr + req_id_t'(k);
            if (!r.found && valid[idx]) begin
                r.found = 1'b1;
                r.idx   = idx;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dsp_pipe.sv
// Free-running pipelined P = ((D + B) * A) + C with an ID/valid sideband.
// Stages: operand capture, pre-add, multiply, LATENCY-4 delays, post-add.
module dsp_pipe
    import dsp_sched_pkg::*;
#(
    parameter int LATENCY   = 4,
    parameter int ABD_WIDTH = ABD_WIDTH_DEF,
    parameter int C_WIDTH   = C_WIDTH_DEF,
    parameter int ID_W      = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [ID_W-1:0]      in_id,
    input  logic [ABD_WIDTH-1:0] in_a,
    input  logic [ABD_WIDTH-1:0] in_b,
    input  logic [ABD_WIDTH-1:0] in_d,
    input  logic [C_WIDTH-1:0]   in_c,
    output logic                 out_valid,
    output logic [ID_W-1:0]      out_id,
    output logic [C_WIDTH-1:0]   out_p
);

    localparam int SUM_W  = ABD_WIDTH + 1;
    localparam int PROD_W = SUM_W + ABD_WIDTH;
    localparam int DLY    = LATENCY - 4;

    typedef struct packed {
        logic               v;
        logic [ID_W-1:0]    id;
        logic [PROD_W-1:0]  prod;
        logic [C_WIDTH-1:0] c;
    } mul_stage_t;

    logic                 s0_v_q;
    logic [ID_W-1:0]      s0_id_q;
    logic [ABD_WIDTH-1:0] s0_a_q, s0_b_q, s0_d_q;
    logic [C_WIDTH-1:0]   s0_c_q;

    logic                 s1_v_q;
    logic [ID_W-1:0]      s1_id_q;
    logic [ABD_WIDTH-1:0] s1_a_q;
    logic [SUM_W-1:0]     s1_sum_q;
    logic [C_WIDTH-1:0]   s1_c_q;

    mul_stage_t           s2_q;
    mul_stage_t           tail;

    logic                 out_v_q;
    logic [ID_W-1:0]      out_id_q;
    logic [C_WIDTH-1:0]   out_p_q;

    // Operand capture, pre-add and multiply stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_v_q   <= 1'b0;
            s0_id_q  <= '0;
            s0_a_q   <= '0;
            s0_b_q   <= '0;
            s0_d_q   <= '0;
            s0_c_q   <= '0;
            s1_v_q   <= 1'b0;
            s1_id_q  <= '0;
            s1_a_q   <= '0;
            s1_sum_q <= '0;
            s1_c_q   <= '0;
            s2_q     <= '0;
        end else begin
            s0_v_q   <= in_valid;
            s0_id_q  <= in_id;
            s0_a_q   <= in_a;
            s0_b_q   <= in_b;
            s0_d_q   <= in_d;
            s0_c_q   <= in_c;
            s1_v_q   <= s0_v_q;
            s1_id_q  <= s0_id_q;
            s1_a_q   <= s0_a_q;
            s1_sum_q <= SUM_W'(s0_d_q) + SUM_W'(s0_b_q);
            s1_c_q   <= s0_c_q;
            s2_q.v    <= s1_v_q;
            s2_q.id   <= s1_id_q;
            s2_q.prod <= PROD_W'(s1_sum_q) * PROD_W'(s1_a_q);
            s2_q.c    <= s1_c_q;
        end
    end

    // Optional balancing delay between the multiplier and the post-adder.
    generate
        if (DLY > 0) begin : g_delay
            mul_stage_t dly_q [DLY];

            // Shift the multiply result and its sideband through the delay line.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < DLY; k++) begin
                        dly_q[k] <= '0;
                    end
                end else begin
                    dly_q[0] <= s2_q;
                    for (int k = 1; k < DLY; k++) begin
                        dly_q[k] <= dly_q[k-1];
                    end
                end
            end

            assign tail = dly_q[DLY-1];
        end else begin : g_nodelay
            assign tail = s2_q;
        end
    endgenerate

    // Post-add stage; the sum wraps modulo 2^C_WIDTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_v_q  <= 1'b0;
            out_id_q <= '0;
            out_p_q  <= '0;
        end else begin
            out_v_q  <= tail.v;
            out_id_q <= tail.id;
            out_p_q  <= C_WIDTH'(tail.prod) + tail.c;
        end
    end

    assign out_valid = out_v_q;
    assign out_id    = out_id_q;
    assign out_p     = out_p_q;

endmodule

// File: rtl/dsp_rr_scheduler.sv
// Round-robin arbiter that feeds N requesters into one shared DSP pipeline
// and routes each result back to the requester that issued it.
module dsp_rr_scheduler
    import dsp_sched_pkg::*;
#(
    parameter int N         = 4,
    parameter int LATENCY   = 4,
    parameter int ABD_WIDTH = ABD_WIDTH_DEF,
    parameter int C_WIDTH   = C_WIDTH_DEF,
    localparam int ID_W     = $clog2(N),
    localparam int CNT_W    = $clog2(LATENCY + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [N-1:0]           req_valid,
    output logic [N-1:0]           req_ready,
    input  logic [N*ABD_WIDTH-1:0] req_a,
    input  logic [N*ABD_WIDTH-1:0] req_b,
    input  logic [N*ABD_WIDTH-1:0] req_d,
    input  logic [N*C_WIDTH-1:0]   req_c,
    output logic [N-1:0]           rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic [C_WIDTH-1:0]     rsp_p,
    output logic [CNT_W-1:0]       inflight
);

    req_id_t              ptr_q, ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [MAX_N-1:0]     valid_ext;
    rr_pick_t             pick;
    logic                 issue;
    logic [ABD_WIDTH-1:0] sel_a, sel_b, sel_d;
    logic [C_WIDTH-1:0]   sel_c;

    logic                 pipe_valid;
    logic [ID_W-1:0]      pipe_id;
    logic [C_WIDTH-1:0]   pipe_p;

    // Grant selection, operand slice mux and next pointer/occupancy.
    always_comb begin
        valid_ext          = '0;
        valid_ext[N-1:0]   = req_valid;
        pick               = rr_pick(valid_ext, ptr_q);
        issue              = pick.found & en & ~rst;
        req_ready          = issue ? (N'(1) << pick.idx) : '0;
        sel_a              = req_a[int'(pick.idx)*ABD_WIDTH +: ABD_WIDTH];
        sel_b              = req_b[int'(pick.idx)*ABD_WIDTH +: ABD_WIDTH];
        sel_d              = req_d[int'(pick.idx)*ABD_WIDTH +: ABD_WIDTH];
        sel_c              = req_c[int'(pick.idx)*C_WIDTH +: C_WIDTH];

        ptr_d = ptr_q;
        if (issue) begin
            ptr_d = (pick.idx == req_id_t'(N - 1)) ? '0 : pick.idx + req_id_t'(1);
        end

        cnt_d = cnt_q;
        case ({issue, pipe_valid})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Round-robin pointer and in-flight counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    dsp_pipe #(
        .LATENCY   (LATENCY),
        .ABD_WIDTH (ABD_WIDTH),
        .C_WIDTH   (C_WIDTH),
        .ID_W      (ID_W)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (issue),
        .in_id     (ID_W'(pick.idx)),
        .in_a      (sel_a),
        .in_b      (sel_b),
        .in_d      (sel_d),
        .in_c      (sel_c),
        .out_valid (pipe_valid),
        .out_id    (pipe_id),
        .out_p     (pipe_p)
    );

    // Decode the returning ID into a one-hot strobe.
    always_comb begin
        rsp_valid = pipe_valid ? (N'(1) << pipe_id) : '0;
    end

    assign rsp_id   = pipe_id;
    assign rsp_p    = pipe_p;
    assign inflight = cnt_q;

endmodule

// File: tb/tb_dsp_rr_scheduler.sv
// Directed and random checks for the round-robin DSP scheduler.
module tb_dsp_rr_scheduler;

    localparam int N  = 4;
    localparam int L  = 4;
    localparam int W  = 18;
    localparam int CW = 48;

    logic            clk;
    logic            rst;
    logic            en;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*W-1:0]  req_a, req_b, req_d;
    logic [N*CW-1:0] req_c;
    logic [N-1:0]    rsp_valid;
    logic [1:0]      rsp_id;
    logic [CW-1:0]   rsp_p;
    logic [2:0]      inflight;

    int checks   = 0;
    int failures = 0;

    dsp_rr_scheduler #(
        .N (N), .LATENCY (L), .ABD_WIDTH (W), .C_WIDTH (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_d     (req_d),
        .req_c     (req_c),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p),
        .inflight  (inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [47:0] ref_p(input logic [17:0] a, input logic [17:0] b,
                                          input logic [17:0] d, input logic [47:0] c);
        logic [63:0] s;
        s = (64'(d) + 64'(b)) * 64'(a) + 64'(c);
        return s[47:0];
    endfunction

    task automatic set_ops(input int i, input logic [17:0] a, input logic [17:0] b,
                           input logic [17:0] d, input logic [47:0] c);
        req_a[i*W +: W]   = a;
        req_b[i*W +: W]   = b;
        req_d[i*W +: W]   = d;
        req_c[i*CW +: CW] = c;
    endtask

    // ---------------- reference monitor ----------------
    typedef struct {
        int          due;
        int          id;
        logic [47:0] p;
    } exp_t;

    exp_t        q[$];
    int          cyc  = 0;
    int          mptr = 0;
    int          m_idx;
    int          m_gnt;
    logic        m_found;
    logic [63:0] m_ready;

    always @(negedge clk) begin
        cyc++;
        chk("inflight", 64'(inflight), 64'(q.size()));
        chk("inflight_le_L", 64'(inflight <= 3'(L)), 64'd1);
        if (q.size() > 0 && q[0].due == cyc) begin
            chk("rsp_valid", 64'(rsp_valid), 64'd1 << q[0].id);
            chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
            chk("rsp_p", 64'(rsp_p), 64'(q[0].p));
            $display("rsp cyc=%0d id=%0d p=%0h", cyc, rsp_id, rsp_p);
            void'(q.pop_front());
        end else begin
            chk("rsp_idle", 64'(rsp_valid), 64'd0);
        end

        m_found = 1'b0;
        m_gnt   = 0;
        if (!rst && en) begin
            for (int k = 0; k < N; k++) begin
                m_idx = (mptr + k) % N;
                if (!m_found && req_valid[m_idx]) begin
                    m_found = 1'b1;
                    m_gnt   = m_idx;
                end
            end
        end
        m_ready = m_found ? (64'd1 << m_gnt) : 64'd0;
        chk("req_ready", 64'(req_ready), m_ready);

        if (rst) begin
            q.delete();
            mptr = 0;
        end else if (m_found) begin
            q.push_back('{due: cyc + L, id: m_gnt,
                          p: ref_p(req_a[m_gnt*W +: W], req_b[m_gnt*W +: W],
                                   req_d[m_gnt*W +: W], req_c[m_gnt*CW +: CW])});
            mptr = (m_gnt + 1) % N;
        end
    end

    // ---------------- directed helpers ----------------
    // One requester alone: check grant, silence until due, then the result.
    task automatic single_op(input int i, input logic [17:0] a, input logic [17:0] b,
                             input logic [17:0] d, input logic [47:0] c,
                             input logic [47:0] exp_p);
        set_ops(i, a, b, d, c);
        req_valid = 4'(1 << i);
        @(negedge clk);
        chk("single_grant", 64'(req_ready), 64'd1 << i);
        for (int k = 1; k <= L; k++) begin
            @(posedge clk); #1;
            if (k == 1) req_valid = '0;
            @(negedge clk);
            if (k < L) chk("single_early", 64'(rsp_valid), 64'd0);
        end
        chk("single_valid", 64'(rsp_valid), 64'd1 << i);
        chk("single_id", 64'(rsp_id), 64'(i));
        chk("single_p", 64'(rsp_p), 64'(exp_p));
        $display("op req=%0d a=%0d b=%0d d=%0d c=%0h p=%0h", i, a, b, d, c, rsp_p);
        @(posedge clk); #1;
    endtask

    logic [47:0] fair_p [4] = '{48'd7, 48'd118, 48'd233, 48'd352};
    logic [2:0]  en_tbl [6] = '{3'd3, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
    logic [N-1:0] gm;

    initial begin
        rst       = 1'b1;
        en        = 1'b1;
        req_valid = '1;
        req_a = '0; req_b = '0; req_d = '0; req_c = '0;
        for (int i = 0; i < N; i++) set_ops(i, 18'(i + 1), 18'(i), 18'(2), 48'(i));

        // Reset with every requester asking.
        repeat (3) begin
            @(negedge clk);
            chk("rst_ready", 64'(req_ready), 64'd0);
            chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("rst_rsp_p", 64'(rsp_p), 64'd0);
            chk("rst_rsp_id", 64'(rsp_id), 64'd0);
            chk("rst_inflight", 64'(inflight), 64'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("first_grant", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (L + 2) begin @(posedge clk); #1; end

        // Single operation, then requester 3 alone to bring ptr back to 0.
        single_op(2, 18'd3, 18'd4, 18'd5, 48'd10, 48'd37);
        single_op(3, 18'd1, 18'd1, 18'd1, 48'd1, 48'd3);

        // Fairness: all four continuously valid for eight grants.
        for (int i = 0; i < N; i++) set_ops(i, 18'(i + 1), 18'(2 * i), 18'd7, 48'(100 * i));
        req_valid = '1;
        for (int k = 0; k < 8 + L; k++) begin
            @(negedge clk);
            if (k < 8) chk("fair_grant", 64'(req_ready), 64'd1 << (k % 4));
            if (k >= L) begin
                chk("fair_rsp_valid", 64'(rsp_valid), 64'd1 << ((k - L) % 4));
                chk("fair_rsp_id", 64'(rsp_id), 64'((k - L) % 4));
                chk("fair_rsp_p", 64'(rsp_p), 64'(fair_p[(k - L) % 4]));
            end
            @(posedge clk); #1;
            if (k == 7) req_valid = '0;
        end

        // Overflow wrap and all-zero operands.
        single_op(1, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 48'hFFFF_FFFF_FFFF, 48'h001F_FFF0_0001);
        single_op(0, 18'd0, 18'd0, 18'd0, 48'd0, 48'd0);

        // Three grants, then en low: pipeline drains with no new grants.
        req_valid = '1;
        repeat (3) begin @(posedge clk); #1; end
        en = 1'b0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            chk("en_inflight", 64'(inflight), 64'(en_tbl[j]));
            chk("en_ready", 64'(req_ready), 64'd0);
            @(posedge clk); #1;
        end

        // Two more grants, then a one-cycle reset discards them.
        en        = 1'b1;
        req_valid = 4'b0011;
        @(negedge clk);
        chk("mr_grant0", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mr_grant1", 64'(req_ready), 64'd2);
        @(posedge clk); #1;
        req_valid = '0;
        rst       = 1'b1;
        @(negedge clk);
        chk("mr_inflight_pre", 64'(inflight), 64'd2);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (L + 2) begin
            @(negedge clk);
            chk("mr_no_rsp", 64'(rsp_valid), 64'd0);
            chk("mr_inflight", 64'(inflight), 64'd0);
            @(posedge clk); #1;
        end

        // Random traffic; operands held until the requester is granted.
        for (int t = 0; t < 1000; t++) begin
            @(negedge clk);
            gm = req_valid & req_ready;
            @(posedge clk); #1;
            en = ($urandom_range(0, 4) != 0);
            for (int i = 0; i < N; i++) begin
                if (gm[i] || !req_valid[i]) begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    if ($urandom_range(0, 7) == 0)
                        set_ops(i, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 48'hFFFF_FFFF_FFFF);
                    else
                        set_ops(i, 18'($urandom()), 18'($urandom()), 18'($urandom()),
                                48'({$urandom(), $urandom()}));
                end
            end
        end
        req_valid = '0;
        repeat (L + 2) begin @(posedge clk); #1; end
        chk("drain_pending", 64'(q.size()), 64'd0);
        chk("drain_inflight", 64'(inflight), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dsp_rr_scheduler.md
# dsp_rr_scheduler

Round-robin scheduler that shares one pipelined DSP datapath, P = ((D + B) * A) + C, between N requesters. Each requester presents an operand set with a valid/ready handshake; the scheduler grants one requester per cycle, issues its operands into the pipeline and tracks the issuing requester's ID alongside each operation. When the operation completes, it returns the result to that requester with a one-cycle valid pulse. It sits between the requester-side engines and the single DSP resource, so no requester drives the DSP directly.

## Interface
Parameters:
- N, 4, number of requesters (2..8)
- LATENCY, 4, registers from operand capture to result output (≥ 4)
- ABD_WIDTH, 18, width of A, B, D
- C_WIDTH, 48, width of C and P

Ports:
- clk  in  1  single clock, rising-edge
- rst  in  1  synchronous, active-high reset
- en  in  1  grant enable; 0 = no new grants, pipeline keeps draining
- req_valid  in  N  per-requester operand valid
- req_ready  out  N  one-hot grant; zero when nothing is granted
- req_a, req_b, req_d  in  N*ABD_WIDTH  packed operands; requester i occupies slice [i*ABD_WIDTH +: ABD_WIDTH]
- req_c  in  N*C_WIDTH  packed C operands, same slicing
- rsp_valid  out  N  one-hot result strobe, one cycle per result
- rsp_id  out  $clog2(N)  requester index of the current result
- rsp_p  out  C_WIDTH  result value
- inflight  out  $clog2(LATENCY+1)  number of operations currently in the pipeline

## Operation
- **Arbitration**
  - Round-robin pointer `ptr`; reset value 0.
  - Grant the first i with req_valid[i], searching from ptr upward and wrapping modulo N.
  - req_ready is combinational from req_valid, ptr and en.
- **Transfer**
  - A transfer occurs when req_valid[i] & req_ready[i] at a rising edge.
  - On a transfer, ptr ← (i+1) mod N. With no transfer, ptr holds.
- **Handshake rules**
  - en=0 or no valid requester: req_ready=0 and ptr holds.
  - A requester keeps valid and its operands stable until it is granted.
- **Issue**
  - On a transfer, the granted slice is captured into the pipeline input registers together with the requester ID and a valid bit.
  - One issue per cycle maximum; full throughput with no bubbles.
- **Arithmetic**
  - D + B is computed at ABD_WIDTH+1 bits (unsigned) and A is multiplied in at full width.
  - The sum with C is truncated modulo 2^C_WIDTH.
  - All operands are unsigned.
- **Completion**
  - rsp_valid = onehot(id) when the final stage's valid bit is 1, otherwise 0.
  - rsp_id and rsp_p are valid only while rsp_valid ≠ 0.
  - There is no response backpressure; requesters must accept results.
- **inflight**
  - Count of valid bits in the pipeline.
  - +1 on issue, −1 on completion; issue and completion in the same cycle leave it unchanged.
- **Reset**
  - Clears all pipeline valid bits, data registers, ptr and inflight.
  - Reset while operations are in flight discards them; no rsp_valid follows.
  - Outputs after reset: req_ready=0 during rst, rsp_valid=0, rsp_id=0, rsp_p=0, inflight=0.

## Timing
- Transfer at edge n → result registered at edge n+LATENCY−1; rsp_valid is high for the single cycle that follows.
- Stage placement:
  - edge n: operand capture
  - n+1: pre-add register
  - n+2: multiply register
  - next LATENCY−4 edges: delay registers
  - last edge: post-add (P) register
- Back-to-back grants at edges n and n+1 give responses in consecutive cycles, in issue order.
- rst asserted at any edge takes effect at that edge. req_ready is 0 while rst=1.

## Structure
- Package dsp_sched_pkg holds:
  - the ABD_WIDTH and C_WIDTH defaults
  - the requester-ID typedef
  - the function `rr_pick(valid, ptr)` returning the grant index and a found flag
- Sub-module dsp_pipe (LATENCY, widths) carries the operands plus an ID/valid sideband. Its only control input is rst; it is otherwise free-running.
- dsp_rr_scheduler contains the arbiter, slice muxing, inflight counter and response decode.

## Test plan
- Reset:
  - Hold rst for 3 cycles with all req_valid=1.
  - Required: req_ready=0, rsp_valid=0, rsp_p=0, inflight=0. First grant after release goes to requester 0.
- Single operation:
  - Requester 2 sends A=3, B=4, C=10, D=5.
  - Required: rsp_valid=4'b0100, rsp_id=2, rsp_p=37, exactly LATENCY cycles after the grant.
- Round-robin fairness:
  - All four requesters valid continuously for 8 cycles.
  - Required: grant order 0,1,2,3,0,1,2,3, and eight consecutive responses in the same order.
- Overflow and wrap:
  - A=B=D=2^18−1, C=2^48−1.
  - Required: rsp_p = ((2^19−2)·(2^18−1) + 2^48−1) mod 2^48.
  - Separately, all operands zero → rsp_p=0.
- Enable and mid-flight reset:
  - Issue 3 operations, drop en: inflight counts down to 0 with no new grants.
  - Then issue 2 more and pulse rst for one cycle after the second grant: no rsp_valid follows and inflight=0.
- Random:
  - 1000 cycles with random valid, operands and en, checked against a reference model.
  - Required: zero mismatches, no response lost or duplicated, and inflight never above LATENCY.
